// File: rtl/carme_rf_pkg.sv
// Shared types for the Carme register-file scan controller: command codes,
// FSM states and the bit positions of the config bus.
package carme_rf_pkg;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'b00,
        CMD_SCAN     = 2'b01,
        CMD_PWR_DOWN = 2'b10,
        CMD_PWR_UP   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWD,
        ST_SETUP,
        ST_BLOCK,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } state_e;

    localparam int CFG_CLK_S  = 0;
    localparam int CFG_SCAN   = 1;
    localparam int CFG_SCAN_E = 2;
    localparam int CFG_PWD    = 3;

    localparam int BLOCK_SHIFTS = 16;

endpackage

// File: rtl/carme_scan_phase_timer.sv
// Half-period timer for CLK_S: counts CLK_DIV cycles while run is high and
// flags the last one; it restarts after the flag or whenever run drops.
module carme_scan_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic last
);
    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign last = run && (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!run || last) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/carme_rf_scan_ctrl.sv
// Scan-chain controller for the Carme register file: streams 16-bit words in,
// clocks them through the chain with a divided CLK_S and packs SCAN_O pairs out.
import carme_rf_pkg::*;

module carme_rf_scan_ctrl #(
    parameter int CHAIN_LEN = 512,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_i,
    input  logic        din_valid_i,
    output logic        din_ready_o,
    input  logic [15:0] din_i,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic [31:0] dout_o,
    output logic        busy_o,
    output logic        pwd_o,
    output logic        done_o,
    output logic        err_o,
    output logic [3:0]  carme_rf_cfg_o,
    input  logic [1:0]  carme_rf_status_i
);
    localparam int SHIFT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN);

    state_e              state_reg, state_next;
    logic [SHIFT_W-1:0]  shift_cnt_reg, shift_cnt_next, shift_cnt_inc;
    logic [15:0]         sr_reg, sr_next;
    logic [31:0]         acc_reg, acc_upd;
    logic [31:0]         dout_reg;
    logic                dout_valid_reg;
    logic [3:0]          cfg_reg, cfg_next;
    logic                cmd_ready_reg, cmd_ready_next;
    logic                busy_reg, busy_next;
    logic                pwd_reg, pwd_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;

    logic                phase_run, phase_last;
    logic                cmd_fire, buf_free, blk_go, capture, blk_end;
    logic [3:0]          bit_idx;

    assign phase_run     = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT_LO) ||
                           (state_reg == ST_SHIFT_HI);
    assign cmd_fire      = cmd_valid_i && cmd_ready_reg;
    assign buf_free      = !dout_valid_reg || dout_ready_i;
    assign blk_go        = (state_reg == ST_BLOCK) && din_valid_i && buf_free;
    assign capture       = (state_reg == ST_SHIFT_HI) && phase_last;
    assign shift_cnt_inc = shift_cnt_reg + 1'b1;
    assign blk_end       = capture && (shift_cnt_inc[3:0] == 4'd0);
    assign bit_idx       = shift_cnt_reg[3:0];

    carme_scan_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (phase_run),
        .last (phase_last)
    );

    // Each SCAN_O pair lands at bit position 2*i for shift i of the block.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_SHIFTS; gi++) begin : g_capture
            assign acc_upd[2*gi +: 2] = (capture && (bit_idx == 4'(gi))) ?
                                        carme_rf_status_i : acc_reg[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        shift_cnt_next = shift_cnt_reg;
        sr_next        = sr_reg;
        err_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_e'(cmd_i))
                        CMD_SCAN: begin
                            state_next     = ST_SETUP;
                            shift_cnt_next = '0;
                        end
                        CMD_PWR_DOWN: state_next = ST_PWD;
                        CMD_PWR_UP:   err_next   = 1'b1;
                        default:      ;
                    endcase
                end
            end
            ST_PWD: begin
                if (cmd_fire) begin
                    case (cmd_e'(cmd_i))
                        CMD_PWR_UP:   state_next = ST_IDLE;
                        CMD_SCAN,
                        CMD_PWR_DOWN: err_next   = 1'b1;
                        default:      ;
                    endcase
                end
            end
            ST_SETUP: begin
                if (phase_last) state_next = ST_BLOCK;
            end
            ST_BLOCK: begin
                if (blk_go) begin
                    sr_next    = din_i;
                    state_next = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_last) state_next = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (phase_last) begin
                    sr_next        = {1'b0, sr_reg[15:1]};
                    shift_cnt_next = shift_cnt_inc;
                    if (shift_cnt_inc[3:0] != 4'd0) begin
                        state_next = ST_SHIFT_LO;
                    end else if (shift_cnt_inc == SHIFT_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_BLOCK;
                    end
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // Outputs are registered from the next state so cfg never glitches.
        cfg_next             = '0;
        cfg_next[CFG_CLK_S]  = (state_next == ST_SHIFT_HI);
        cfg_next[CFG_SCAN]   = (state_next == ST_SHIFT_LO) && sr_next[0];
        cfg_next[CFG_SCAN_E] = state_next inside {ST_SETUP, ST_BLOCK, ST_SHIFT_LO, ST_SHIFT_HI};
        cfg_next[CFG_PWD]    = (state_next == ST_PWD);
        cmd_ready_next       = state_next inside {ST_IDLE, ST_PWD};
        busy_next            = state_next inside {ST_SETUP, ST_BLOCK, ST_SHIFT_LO,
                                                  ST_SHIFT_HI, ST_DONE};
        pwd_next             = (state_next == ST_PWD);
        done_next            = (state_next == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            shift_cnt_reg <= '0;
            sr_reg        <= '0;
            cfg_reg       <= '0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            pwd_reg       <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_cnt_reg <= shift_cnt_next;
            sr_reg        <= sr_next;
            cfg_reg       <= cfg_next;
            cmd_ready_reg <= cmd_ready_next;
            busy_reg      <= busy_next;
            pwd_reg       <= pwd_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    // A completed block only ever finds the output buffer free, because
    // BLOCK refuses to start a new block while the previous word is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg        <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (capture) acc_reg <= acc_upd;
            if (blk_end) begin
                dout_reg       <= acc_upd;
                dout_valid_reg <= 1'b1;
            end else if (dout_valid_reg && dout_ready_i) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign cmd_ready_o    = cmd_ready_reg;
    assign din_ready_o    = blk_go;
    assign dout_valid_o   = dout_valid_reg;
    assign dout_o         = dout_reg;
    assign busy_o         = busy_reg;
    assign pwd_o          = pwd_reg;
    assign done_o         = done_reg;
    assign err_o          = err_reg;
    assign carme_rf_cfg_o = cfg_reg;

endmodule

// File: tb/tb_carme_rf_scan_ctrl.sv
// Bench for carme_rf_scan_ctrl: stimulus pushes expected words and scan bits
// into queues; independent monitors pop and compare what the DUT presents.
import carme_rf_pkg::*;

module tb_carme_rf_scan_ctrl;
    localparam int CHAIN_LEN = 32;
    localparam int CLK_DIV   = 2;
    localparam int NBLK      = CHAIN_LEN / 16;
    localparam int PERIOD    = 2 * CLK_DIV;
    // accept cycle -> SETUP -> per block (1 BLOCK cycle + 16 full CLK_S periods) -> DONE
    localparam int SCAN_LAT  = 1 + CLK_DIV + NBLK * (1 + 16 * PERIOD);

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd;
    logic        din_valid, din_ready;
    logic [15:0] din;
    logic        dout_valid, dout_ready;
    logic [31:0] dout;
    logic        busy, pwd, done, err;
    logic [3:0]  cfg;
    logic [1:0]  status;

    always #5 clk = ~clk;

    carme_rf_scan_ctrl #(
        .CHAIN_LEN (CHAIN_LEN),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_i             (cmd),
        .din_valid_i       (din_valid),
        .din_ready_o       (din_ready),
        .din_i             (din),
        .dout_valid_o      (dout_valid),
        .dout_ready_i      (dout_ready),
        .dout_o            (dout),
        .busy_o            (busy),
        .pwd_o             (pwd),
        .done_o            (done),
        .err_o             (err),
        .carme_rf_cfg_o    (cfg),
        .carme_rf_status_i (status)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rises = 0;
    int          last_rises = 0;
    int          hold_until = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] exp_dout_q[$];
    logic        exp_bit_q[$];
    logic [1:0]  tbl[CHAIN_LEN];
    logic [15:0] din_words[NBLK];
    logic [3:0]  mon_prev_cfg = 4'd0;
    int          mon_last_rise = 0;
    logic        drv_prev_clks = 1'b0;
    int          drv_falls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out, required event never seen (cycle %0d)", name, cyc);
    endtask

    // Register-file model: SCAN_O for shift j is tbl[j], advancing on each CLK_S fall.
    initial begin
        status = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (!busy) drv_falls = 0;
            else if (drv_prev_clks && !cfg[CFG_CLK_S]) drv_falls++;
            drv_prev_clks = cfg[CFG_CLK_S];
            status = tbl[drv_falls % CHAIN_LEN];
        end
    end

    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dout_ready = (cyc >= hold_until) && (!rand_ready || ($urandom_range(0, 1) == 1));
        end
    end

    // Output-word scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && dout_valid && dout_ready) begin
                $display("dout word 0x%08h at cycle %0d", dout, cyc);
                if (exp_dout_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL dout_unexpected: got 0x%08h, required no word", dout);
                end else begin
                    check("dout_word", dout, exp_dout_q.pop_front());
                end
            end
        end
    end

    // Scan-bit, CLK_S period and cfg legality monitor.
    initial begin
        logic ok;
        forever begin
            @(negedge clk);
            if (!busy) rises = 0;
            if (!rst) begin
                if (!mon_prev_cfg[CFG_CLK_S] && cfg[CFG_CLK_S]) begin
                    if (exp_bit_q.size() == 0) timeout("scan_bit_unexpected");
                    else check("scan_bit", mon_prev_cfg[CFG_SCAN], exp_bit_q.pop_front());
                    if (rises % 16 != 0) check("clk_s_period", cyc - mon_last_rise, PERIOD);
                    mon_last_rise = cyc;
                    rises++;
                end
                ok = 1'b1;
                if (cfg[CFG_PWD] && cfg != 4'b1000) ok = 1'b0;
                if (cfg[CFG_PWD] != pwd) ok = 1'b0;
                if (cfg[CFG_SCAN] && (!cfg[CFG_SCAN_E] || cfg[CFG_CLK_S])) ok = 1'b0;
                if (cfg[CFG_CLK_S] && !cfg[CFG_SCAN_E]) ok = 1'b0;
                if (cmd_ready && busy) ok = 1'b0;
                check("cfg_legal", ok, 1'b1);
            end
            mon_prev_cfg = cfg;
        end
    end

    task automatic send_cmd(input logic [1:0] c, output int acc_cyc);
        int t = 0;
        @(posedge clk);
        #1;
        cmd = c;
        cmd_valid = 1'b1;
        acc_cyc = cyc;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            if (++t > 300) begin
                timeout("cmd_accept");
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("cmd %0d accepted at cycle %0d", c, acc_cyc);
    endtask

    task automatic send_din(input logic [15:0] w, input int gap);
        int t = 0;
        @(posedge clk);
        #1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        din = w;
        din_valid = 1'b1;
        for (int i = 0; i < 16; i++) exp_bit_q.push_back(w[i]);
        forever begin
            @(negedge clk);
            if (din_ready) break;
            if (++t > 2000) begin
                timeout("din_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din = 16'($urandom);
        $display("din word 0x%04h accepted at cycle %0d", w, cyc);
    endtask

    task automatic wait_done(output int dcyc);
        int t = 0;
        dcyc = cyc;
        forever begin
            @(negedge clk);
            if (done) break;
            if (++t > 3000) begin
                timeout("done_wait");
                return;
            end
        end
        dcyc = cyc;
        last_rises = rises;
        @(negedge clk);
        check("done_width", done, 1'b0);
    endtask

    task automatic run_scan(input int max_gap, output int lat);
        int a;
        int d;
        logic [31:0] w;
        for (int b = 0; b < NBLK; b++) begin
            w = '0;
            for (int i = 0; i < 16; i++) w[2*i +: 2] = tbl[16*b + i];
            exp_dout_q.push_back(w);
        end
        send_cmd(CMD_SCAN, a);
        for (int b = 0; b < NBLK; b++) send_din(din_words[b], int'($urandom_range(0, max_gap)));
        wait_done(d);
        lat = d - a;
        $display("scan accepted %0d done %0d latency %0d", a, d, lat);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_dout_q.size() != 0) begin
            @(negedge clk);
            if (++t > 1000) begin
                timeout("dout_drain");
                break;
            end
        end
        check("dout_queue_empty", exp_dout_q.size(), 0);
        check("bit_queue_empty", exp_bit_q.size(), 0);
    endtask

    task automatic randomize_scan();
        for (int i = 0; i < CHAIN_LEN; i++) tbl[i] = 2'($urandom);
        for (int b = 0; b < NBLK; b++) din_words[b] = 16'($urandom);
    endtask

    initial begin
        int a;
        int lat;
        int t;
        logic ok;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd = 2'b00;
        din_valid = 1'b0;
        din = 16'h0;
        for (int i = 0; i < CHAIN_LEN; i++) tbl[i] = 2'b00;

        repeat (3) @(negedge clk);
        check("reset_cfg", cfg, 4'b0000);
        check("reset_status", {cmd_ready, busy, pwd, done, err, dout_valid}, 6'b0);
        check("reset_dout", dout, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_cmd_ready", cmd_ready, 1'b1);

        send_cmd(CMD_NOP, a);
        check("nop_err", err, 1'b0);
        check("nop_busy", busy, 1'b0);
        send_cmd(CMD_PWR_UP, a);
        check("idle_pwrup_err", err, 1'b1);
        @(posedge clk);
        #1;
        check("err_pulse_width", err, 1'b0);

        send_cmd(CMD_PWR_DOWN, a);
        check("pwd_cfg", cfg, 4'b1000);
        check("pwd_flag", pwd, 1'b1);
        send_cmd(CMD_SCAN, a);
        check("pwd_scan_err", err, 1'b1);
        check("pwd_scan_cfg", cfg, 4'b1000);
        send_cmd(CMD_PWR_UP, a);
        check("pwrup_cfg", cfg, 4'b0000);
        check("pwrup_pwd", pwd, 1'b0);
        check("pwrup_ready", cmd_ready, 1'b1);

        // Directed full scan: A5A5/0F0F in, SCAN_O held at 2'b10.
        for (int i = 0; i < CHAIN_LEN; i++) tbl[i] = 2'b10;
        din_words[0] = 16'hA5A5;
        din_words[1] = 16'h0F0F;
        run_scan(0, lat);
        check("scan_latency", lat, SCAN_LAT);
        check("rise_count", last_rises, CHAIN_LEN);
        drain();

        // Output backpressure holds the second block in BLOCK.
        randomize_scan();
        hold_until = cyc + 100;
        fork
            run_scan(0, lat);
            begin
                repeat (90) @(negedge clk);
                check("bp_cfg", cfg, 4'b0100);
                check("bp_busy", busy, 1'b1);
                check("bp_dout_valid", dout_valid, 1'b1);
                check("bp_din_ready", din_ready, 1'b0);
            end
        join
        check("bp_latency_grew", lat > SCAN_LAT, 1'b1);
        drain();

        // Reset during shift 10 aborts the scan without any output.
        randomize_scan();
        send_cmd(CMD_SCAN, a);
        send_din(din_words[0], 0);
        t = 0;
        while (!(rises >= 10 && !cfg[CFG_CLK_S])) begin
            @(negedge clk);
            if (++t > 500) begin
                timeout("shift10_wait");
                break;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_cfg", cfg, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_bit_q.delete();
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done || dout_valid || busy) ok = 1'b0;
        end
        check("rst_quiet", ok, 1'b1);

        randomize_scan();
        run_scan(0, lat);
        check("post_rst_latency", lat, SCAN_LAT);
        drain();

        // Random scans with random input gaps and random output readiness.
        rand_ready = 1'b1;
        repeat (6) begin
            randomize_scan();
            run_scan(3, lat);
            check("rand_latency_min", lat >= SCAN_LAT, 1'b1);
        end
        rand_ready = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/carme_rf_scan_ctrl.md
CARME_RF_SCAN_CTRL -- requirements
Module: carme_rf_scan_ctrl

Interface
REQ-001 CHAIN_LEN, 512, shifts per full scan op; SHALL be a multiple of 16 and at least 16.
REQ-002 CLK_DIV, 4, clk cycles per CLK_S half-period; SHALL be at least 1.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake; a command transfers when both are high.
REQ-006 cmd_i  in  2  command code: 00 NOP, 01 SCAN, 10 PWR_DOWN, 11 PWR_UP.
REQ-007 din_valid_i / din_ready_o / din_i  in/out/in  1/1/16  scan-in word stream, one word per 16-shift block.
REQ-008 dout_valid_o / dout_ready_i / dout_o  out/in/out  1/1/32  scan-out word stream, one word per 16-shift block.
REQ-009 busy_o, pwd_o, done_o, err_o  out  1 each  status outputs: op in progress, power-down held, scan complete (1-cycle pulse), illegal command (1-cycle pulse).
REQ-010 carme_rf_cfg_o  out  4  register-file config: [0] CLK_S, [1] SCAN, [2] SCAN_E, [3] power-down (PWD_N inverted).
REQ-011 carme_rf_status_i  in  2  SCAN_O chain outputs from the register file.

Function
REQ-012 States SHALL be IDLE, PWD, SETUP, BLOCK, SHIFT_LO, SHIFT_HI, DONE.
REQ-013 cmd_ready_o SHALL be high only in IDLE and PWD.
REQ-014 In IDLE, NOP SHALL be a no-op, SCAN SHALL go to SETUP, PWR_DOWN SHALL go to PWD, and PWR_UP SHALL pulse err_o and stay in IDLE.
REQ-015 In PWD, cfg[3]=1 and pwd_o=1; PWR_UP SHALL go to IDLE next cycle; SCAN or PWR_DOWN SHALL pulse err_o and stay in PWD.
REQ-016 SETUP SHALL last CLK_DIV cycles with SCAN_E=1 and CLK_S=0, then go to BLOCK.
REQ-017 SCAN_E SHALL be 1 from SETUP through the last SHIFT_HI, and 0 in all other states.
REQ-018 BLOCK (at least 1 cycle) SHALL wait until din_valid_i=1 and the output buffer is free (dout_valid_o=0, or handshaking in this cycle).
REQ-019 On BLOCK exit, din_ready_o SHALL pulse, din_i SHALL load a 16-bit shift register, and the state SHALL go to SHIFT_LO.
REQ-020 SHIFT_LO SHALL last CLK_DIV cycles with CLK_S=0 and SCAN = shift-register bit 0 (LSB first).
REQ-021 SHIFT_HI SHALL last CLK_DIV cycles with CLK_S=1.
REQ-022 On the last SHIFT_HI cycle, carme_rf_status_i SHALL be captured into dout bits [2i+1:2i] for shift i of the block, and the shift register SHALL shift right.
REQ-023 After the 16th shift of a block, dout_o SHALL update and dout_valid_o SHALL rise on the next cycle and hold until dout_ready_i.
REQ-024 After the 16th shift, the state SHALL go to BLOCK, or to DONE once CHAIN_LEN shifts are complete.
REQ-025 DONE SHALL last 1 cycle with done_o=1, then go to IDLE; a pending final dout word SHALL NOT delay DONE.
REQ-026 busy_o SHALL be 1 in SETUP through DONE.
REQ-027 Outside SHIFT_LO, SCAN SHALL be 0; cfg[3] SHALL be 0 outside PWD.
REQ-028 All cfg outputs SHALL come directly from flops (glitch-free CLK_S).
REQ-029 Shift counter width SHALL be $clog2(CHAIN_LEN+1), and phase counter width $clog2(CLK_DIV+1); neither SHALL wrap.

Reset
REQ-030 rst SHALL immediately force IDLE, carme_rf_cfg_o=0, and all handshake/status outputs, dout_o and counters to 0.
REQ-031 rst mid-scan SHALL abort the op with no done_o and discard the partial dout word.

Structure
REQ-032 carme_rf_pkg SHALL hold the cmd enum, the state enum and the cfg bit-index constants (CFG_CLK_S=0, CFG_SCAN=1, CFG_SCAN_E=2, CFG_PWD=3).
REQ-033 The CLK_S half-period timer SHALL be a sub-module, carme_scan_phase_timer (start, CLK_DIV count, last-cycle flag).

Verification (CHAIN_LEN=32, CLK_DIV=2)
REQ-034 Full scan: SCAN, din words 0xA5A5 then 0x0F0F always valid, status held at 2'b10, dout_ready_i=1 -> dout words 0xAAAAAAAA twice.
REQ-035 Same scan: SCAN bit sequence LSB-first 1,0,1,0…; exactly 32 CLK_S rising edges of 4-clk period; done_o 1 cycle, 133 cycles after command accept.
REQ-036 Backpressure: dout_ready_i=0 until cycle 100 -> second block held in BLOCK, CLK_S low, SCAN_E high; the scan then completes with no lost or duplicated word.
REQ-037 Power: PWR_DOWN -> cfg=4'b1000 and pwd_o=1; then SCAN -> err_o pulse, cfg unchanged; then PWR_UP -> cfg=0 and IDLE.
REQ-038 Reset mid-op: rst asserted during shift 10 -> same-cycle cfg=0, busy_o=0, no done_o, no dout_valid_o; a following SCAN runs normally.
